// File: rtl/decoder_scan_arbiter_pkg.sv
// Shared types for the decoder scan arbiter: FSM encoding and requester width.
// Combinational helpers only; no latency, no backpressure.
package decoder_scan_arbiter_pkg;

    localparam int NREQ   = 8;
    localparam int NREQ_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    function automatic logic [NREQ-1:0] onehot_n(input logic [NREQ_W-1:0] idx);
        return ~(NREQ'(1) << idx);
    endfunction

endpackage

// File: rtl/decoder_scan_arbiter_rr_pick8.sv
// Round-robin picker: first low request at or after i_ptr, wrapping mod 8.
// Purely combinational, zero latency; no backpressure.
module rr_pick8
    import decoder_scan_arbiter_pkg::*;
(
    input  logic [NREQ-1:0]   i_req_n,
    input  logic [NREQ_W-1:0] i_ptr,
    output logic              o_valid,
    output logic [NREQ_W-1:0] o_w
);

    logic [NREQ_W-1:0] w_idx;
    logic              w_found;
    logic [NREQ_W-1:0] w_win;

    always_comb begin
        w_idx   = '0;
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = i_ptr + NREQ_W'(k);
            if (!w_found && !i_req_n[w_idx]) begin
                w_win   = w_idx;
                w_found = 1'b1;
            end
        end
    end

    assign o_valid = w_found;
    assign o_w     = w_win;

endmodule

// File: rtl/decoder_scan_arbiter.sv
// Round-robin owner of a shared 3-to-8 decoder; grant registered one edge after the request is sampled.
// No backpressure: a grant ends on release, EN low or MAX_HOLD timeout, followed by GAP_CYC idle cycles.
module decoder_scan_arbiter
    import decoder_scan_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int GAP_CYC  = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic [NREQ-1:0]   i_req_n,
    output logic              o_s1,
    output logic              o_s2_n,
    output logic              o_s3_n,
    output logic [NREQ_W-1:0] o_a,
    output logic [NREQ-1:0]   o_gnt_n,
    output logic              o_busy,
    output logic              o_to
);

    localparam logic [7:0] LP_MAX_HOLD = 8'(MAX_HOLD);
    localparam logic [3:0] LP_GAP_CYC  = 4'(GAP_CYC);

    state_t              r_state;
    state_t              w_nxt_state;
    logic [NREQ_W-1:0]   r_ptr;
    logic [7:0]          r_hcnt;
    logic [3:0]          r_gcnt;
    logic [NREQ_W-1:0]   r_a;
    logic [NREQ-1:0]     r_gnt_n;
    logic                r_s1;
    logic                r_s2_n;
    logic                r_s3_n;
    logic                r_busy;
    logic                r_to;

    logic                w_valid;
    logic [NREQ_W-1:0]   w_win;
    logic                w_end;
    logic                w_timeout;
    logic                w_start;
    logic [NREQ_W-1:0]   w_nxt_a;
    logic [NREQ-1:0]     w_nxt_gnt_n;
    logic                w_nxt_on;

    rr_pick8 u_pick (
        .i_req_n (i_req_n),
        .i_ptr   (r_ptr),
        .o_valid (w_valid),
        .o_w     (w_win)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    // Release (or EN drop) is tested before the hold limit so it wins a tie and TO stays low.
    always_comb begin
        w_nxt_state = r_state;
        w_end       = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_en && w_valid) begin
                    w_nxt_state = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (i_req_n[r_a] || !i_en) begin
                    w_end = 1'b1;
                end else if (r_hcnt == LP_MAX_HOLD) begin
                    w_end     = 1'b1;
                    w_timeout = 1'b1;
                end
                if (w_end) begin
                    w_nxt_state = (GAP_CYC > 0) ? ST_GAP : ST_IDLE;
                end
            end
            ST_GAP: begin
                if (r_gcnt == LP_GAP_CYC) begin
                    w_nxt_state = ST_IDLE;
                end
            end
            default: w_nxt_state = ST_IDLE;
        endcase
    end

    assign w_start = (r_state == ST_IDLE) && (w_nxt_state == ST_GRANT);

    always_comb begin
        w_nxt_on    = (w_nxt_state == ST_GRANT);
        w_nxt_a     = '0;
        w_nxt_gnt_n = '1;
        if (w_nxt_on) begin
            w_nxt_a     = w_start ? w_win : r_a;
            w_nxt_gnt_n = onehot_n(w_nxt_a);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr  <= '0;
            r_hcnt <= '0;
            r_gcnt <= '0;
        end else begin
            if (w_start) begin
                r_ptr  <= w_win + NREQ_W'(1);
                r_hcnt <= 8'd1;
            end else if (r_state == ST_GRANT && !w_end) begin
                r_hcnt <= r_hcnt + 8'd1;
            end
            if (w_end) begin
                r_gcnt <= 4'd1;
            end else if (r_state == ST_GAP && w_nxt_state == ST_GAP) begin
                r_gcnt <= r_gcnt + 4'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a     <= '0;
            r_gnt_n <= '1;
            r_s1    <= 1'b0;
            r_s2_n  <= 1'b1;
            r_s3_n  <= 1'b1;
            r_busy  <= 1'b0;
            r_to    <= 1'b0;
        end else begin
            r_a     <= w_nxt_a;
            r_gnt_n <= w_nxt_gnt_n;
            r_s1    <= w_nxt_on;
            r_s2_n  <= !w_nxt_on;
            r_s3_n  <= !w_nxt_on;
            r_busy  <= w_nxt_on;
            r_to    <= w_timeout;
        end
    end

    assign o_a     = r_a;
    assign o_gnt_n = r_gnt_n;
    assign o_s1    = r_s1;
    assign o_s2_n  = r_s2_n;
    assign o_s3_n  = r_s3_n;
    assign o_busy  = r_busy;
    assign o_to    = r_to;

endmodule

// File: tb/tb_decoder_scan_arbiter.sv
// Directed bench: dut_a (MAX_HOLD=4, GAP_CYC=1) and dut_b (MAX_HOLD=2, GAP_CYC=1) share clock, reset and EN.
module tb_decoder_scan_arbiter;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] req_a;
    logic [7:0] req_b;

    logic       a_s1, a_s2_n, a_s3_n, a_busy, a_to;
    logic [2:0] a_a;
    logic [7:0] a_gnt_n;
    logic       b_s1, b_s2_n, b_s3_n, b_busy, b_to;
    logic [2:0] b_a;
    logic [7:0] b_gnt_n;

    int checks = 0;
    int errors = 0;

    decoder_scan_arbiter #(.MAX_HOLD(4), .GAP_CYC(1)) dut_a (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_en    (en),
        .i_req_n (req_a),
        .o_s1    (a_s1),
        .o_s2_n  (a_s2_n),
        .o_s3_n  (a_s3_n),
        .o_a     (a_a),
        .o_gnt_n (a_gnt_n),
        .o_busy  (a_busy),
        .o_to    (a_to)
    );

    decoder_scan_arbiter #(.MAX_HOLD(2), .GAP_CYC(1)) dut_b (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_en    (en),
        .i_req_n (req_b),
        .o_s1    (b_s1),
        .o_s2_n  (b_s2_n),
        .o_s3_n  (b_s3_n),
        .o_a     (b_a),
        .o_gnt_n (b_gnt_n),
        .o_busy  (b_busy),
        .o_to    (b_to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [15:0] obs_a = {a_s1, a_s2_n, a_s3_n, a_a, a_gnt_n, a_busy, a_to};
    wire [15:0] obs_b = {b_s1, b_s2_n, b_s3_n, b_a, b_gnt_n, b_busy, b_to};

    // Expected packed output vector {S1,S2_,S3_,A,GNT_,BUSY,TO}.
    function automatic logic [15:0] ev(input bit g, input int w, input bit t);
        logic [7:0] one;
        one = 8'd1 << w;
        if (g) return {1'b1, 1'b0, 1'b0, 3'(w), ~one, 1'b1, t};
        return {1'b0, 1'b1, 1'b1, 3'd0, 8'hFF, 1'b0, t};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; req_a = 8'hFF; req_b = 8'hFF;
        repeat (3) tick();
        checks++;
        if (obs_a !== ev(0, 0, 0)) begin
            errors++; $display("FAIL reset_a got %h exp %h", obs_a, ev(0, 0, 0));
        end
        checks++;
        if (obs_b !== ev(0, 0, 0)) begin
            errors++; $display("FAIL reset_b got %h exp %h", obs_b, ev(0, 0, 0));
        end
        rst_n = 1'b1; en = 1'b1;
        tick();
    endtask

    // Requester 2 holds 3 cycles then releases; one gap cycle follows.
    task automatic test_single();
        req_a = 8'hFB;
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs_a !== ev(1, 2, 0)) begin
                errors++; $display("FAIL single_hold%0d got %h exp %h", i, obs_a, ev(1, 2, 0));
            end
            if (i == 2) req_a = 8'hFF;
            tick();
        end
        checks++;
        if (obs_a !== ev(0, 0, 0)) begin
            errors++; $display("FAIL single_release got %h exp %h", obs_a, ev(0, 0, 0));
        end
        tick();
        checks++;
        if (obs_a !== ev(0, 0, 0)) begin
            errors++; $display("FAIL single_gap got %h exp %h", obs_a, ev(0, 0, 0));
        end
    endtask

    // PTR=3 now; requester 0 alone times out after 4 cycles, is re-granted, then releases on the limit edge.
    task automatic test_timeout();
        req_a = 8'hFE;
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_a !== ev(1, 0, 0)) begin
                errors++; $display("FAIL timeout_hold%0d got %h exp %h", i, obs_a, ev(1, 0, 0));
            end
            tick();
        end
        checks++;
        if (obs_a !== ev(0, 0, 1)) begin
            errors++; $display("FAIL timeout_pulse got %h exp %h", obs_a, ev(0, 0, 1));
        end
        tick();
        checks++;
        if (obs_a !== ev(0, 0, 0)) begin
            errors++; $display("FAIL timeout_gap got %h exp %h", obs_a, ev(0, 0, 0));
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_a !== ev(1, 0, 0)) begin
                errors++; $display("FAIL regrant_hold%0d got %h exp %h", i, obs_a, ev(1, 0, 0));
            end
            if (i == 3) req_a = 8'hFF;
            tick();
        end
        checks++;
        if (obs_a !== ev(0, 0, 0)) begin
            errors++; $display("FAIL release_vs_timeout got %h exp %h", obs_a, ev(0, 0, 0));
        end
        repeat (2) tick();
    endtask

    // Grant 5 puts PTR at 6; lone request 0 wins, then all-request picks 1.
    task automatic test_wrap();
        req_a = 8'hDF;
        tick();
        checks++;
        if (obs_a !== ev(1, 5, 0)) begin
            errors++; $display("FAIL wrap_set5 got %h exp %h", obs_a, ev(1, 5, 0));
        end
        req_a = 8'hFF;
        repeat (2) tick();
        req_a = 8'hFE;
        tick();
        checks++;
        if (obs_a !== ev(1, 0, 0)) begin
            errors++; $display("FAIL wrap_win0 got %h exp %h", obs_a, ev(1, 0, 0));
        end
        req_a = 8'hFF;
        repeat (2) tick();
        req_a = 8'h00;
        tick();
        checks++;
        if (obs_a !== ev(1, 1, 0)) begin
            errors++; $display("FAIL wrap_ptr1 got %h exp %h", obs_a, ev(1, 1, 0));
        end
        req_a = 8'hFF;
        repeat (2) tick();
    endtask

    // EN low blocks grants and keeps PTR (=2); EN drop ends an active grant.
    task automatic test_en_low();
        en = 1'b0;
        req_a = 8'h00;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (obs_a !== ev(0, 0, 0)) begin
                errors++; $display("FAIL en_low%0d got %h exp %h", i, obs_a, ev(0, 0, 0));
            end
        end
        en = 1'b1;
        tick();
        checks++;
        if (obs_a !== ev(1, 2, 0)) begin
            errors++; $display("FAIL en_resume got %h exp %h", obs_a, ev(1, 2, 0));
        end
        en = 1'b0;
        tick();
        checks++;
        if (obs_a !== ev(0, 0, 0)) begin
            errors++; $display("FAIL en_drop got %h exp %h", obs_a, ev(0, 0, 0));
        end
        req_a = 8'hFF;
        en = 1'b1;
        repeat (2) tick();
    endtask

    // All requesting with MAX_HOLD=2: winners 0..7,0, each 2 cycles then TO pulse and an idle cycle.
    task automatic test_round_robin();
        req_b = 8'h00;
        for (int k = 0; k < 9; k++) begin
            tick();
            for (int c = 0; c < 2; c++) begin
                checks++;
                if (obs_b !== ev(1, k % 8, 0)) begin
                    errors++; $display("FAIL rr_grant%0d_c%0d got %h exp %h", k, c, obs_b, ev(1, k % 8, 0));
                end
                tick();
            end
            checks++;
            if (obs_b !== ev(0, 0, 1)) begin
                errors++; $display("FAIL rr_to%0d got %h exp %h", k, obs_b, ev(0, 0, 1));
            end
            tick();
            checks++;
            if (obs_b !== ev(0, 0, 0)) begin
                errors++; $display("FAIL rr_gap%0d got %h exp %h", k, obs_b, ev(0, 0, 0));
            end
        end
    endtask

    // Async reset mid-grant clears outputs without a clock edge and returns PTR to 0.
    task automatic test_reset_mid_grant();
        tick();
        checks++;
        if (obs_b !== ev(1, 1, 0)) begin
            errors++; $display("FAIL pre_reset_grant got %h exp %h", obs_b, ev(1, 1, 0));
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (obs_b !== ev(0, 0, 0)) begin
            errors++; $display("FAIL async_reset got %h exp %h", obs_b, ev(0, 0, 0));
        end
        #2 rst_n = 1'b1;
        tick();
        checks++;
        if (obs_b !== ev(1, 0, 0)) begin
            errors++; $display("FAIL reset_ptr0 got %h exp %h", obs_b, ev(1, 0, 0));
        end
        req_b = 8'hFF;
        repeat (3) tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_timeout();
        test_wrap();
        test_en_low();
        test_round_robin();
        test_reset_mid_grant();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
